// File: rtl/ldpc_frame_ctrl_if.sv
// Stream bundle of the LDPC frame controller.
// LLR beats flow in; hard-decision beats, flags and iteration count flow out.
interface ldpc_frame_ctrl_if #(
  parameter int data_w = 5,
  parameter int D      = 96,
  parameter int it_w   = 6
);
  logic                in_valid;
  logic                in_ready;
  logic [D*data_w-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [D-1:0]        out_data;
  logic                out_last;
  logic [1:0]          out_flags;
  logic [it_w-1:0]     out_iter;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_flags, out_iter
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_flags, out_iter
  );
endinterface

// File: rtl/ldpc_frame_ctrl.sv
// Frame sequencer for ldpc_core: loads R beats of LLRs, restarts and runs the core
// under a watchdog, then streams R beats of hard decisions with flags and iteration count.
module ldpc_frame_ctrl #(
  parameter int data_w  = 5,
  parameter int R       = 24,
  parameter int D       = 96,
  parameter int MAX_CYC = 40,
  parameter int it_w    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  ldpc_frame_ctrl_if.slave      s,
  output logic                  o_busy,
  output logic                  o_core_rst,
  output logic                  o_core_en,
  output logic [R*D*data_w-1:0] o_core_sig,
  input  logic [R*D-1:0]        i_core_res,
  input  logic [1:0]            i_core_status
);
  localparam int BW     = (R > 1) ? $clog2(R) : 1;
  localparam int BEAT_W = D * data_w;

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_START  = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_UNLOAD = 2'd3;

  localparam logic [BW-1:0]   LAST_BEAT = BW'(R - 1);
  localparam logic [BW-1:0]   BEAT_ONE  = BW'(1);
  localparam logic [it_w-1:0] ITER_ONE  = it_w'(1);
  localparam logic [it_w-1:0] ITER_MAX  = it_w'(MAX_CYC);
  localparam logic [it_w-1:0] ITER_LAST = it_w'(MAX_CYC - 1);

  logic [1:0]            r_state;
  logic [BW-1:0]         r_beat;
  logic [it_w-1:0]       r_iter;
  logic [R*D*data_w-1:0] r_sig;
  logic [1:0]            r_flags;
  logic [it_w-1:0]       r_out_iter;
  logic                  r_rst_pulse;
  logic                  r_timeout;

  logic                  w_in_hs;
  logic                  w_out_hs;
  logic                  w_last_beat;
  logic                  w_core_en;
  logic [D-1:0]          w_out_data;

  // Handshake and enable decode; enable drops the same cycle the core reports termination.
  always_comb begin
    w_last_beat = (r_beat == LAST_BEAT);
    w_in_hs     = (r_state == S_LOAD) && s.in_valid;
    w_out_hs    = (r_state == S_UNLOAD) && s.out_ready;
    w_core_en   = (r_state == S_RUN) && (i_core_status == 2'b00);
    if (r_timeout) begin
      w_out_data = '0;
    end else begin
      w_out_data = i_core_res[r_beat*D +: D];
    end
  end

  // Frame sequencing, iteration counting, watchdog and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_LOAD;
      r_beat      <= '0;
      r_iter      <= '0;
      r_flags     <= 2'b00;
      r_out_iter  <= '0;
      r_rst_pulse <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_rst_pulse <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (w_in_hs) begin
            if (w_last_beat) begin
              r_beat      <= '0;
              r_rst_pulse <= 1'b1;
              r_state     <= S_START;
            end else begin
              r_beat <= r_beat + BEAT_ONE;
            end
          end
        end
        S_START: begin
          r_iter  <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (i_core_status != 2'b00) begin
            r_flags    <= i_core_status;
            r_out_iter <= r_iter;
            r_timeout  <= 1'b0;
            r_beat     <= '0;
            r_state    <= S_UNLOAD;
          end else begin
            // The watchdog trips on the MAX_CYC-th enabled cycle so en is never seen again.
            r_iter <= r_iter + ITER_ONE;
            if (r_iter == ITER_LAST) begin
              r_flags    <= 2'b11;
              r_out_iter <= ITER_MAX;
              r_timeout  <= 1'b1;
              r_beat     <= '0;
              r_state    <= S_UNLOAD;
            end
          end
        end
        S_UNLOAD: begin
          if (w_out_hs) begin
            if (w_last_beat) begin
              r_beat  <= '0;
              r_state <= S_LOAD;
            end else begin
              r_beat <= r_beat + BEAT_ONE;
            end
          end
        end
        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

  // Frame buffer: written only by accepted input beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= '0;
    end else if (w_in_hs) begin
      r_sig[r_beat*BEAT_W +: BEAT_W] <= s.in_data;
    end else begin
      r_sig <= r_sig;
    end
  end

  assign s.in_ready  = (r_state == S_LOAD);
  assign s.out_valid = (r_state == S_UNLOAD);
  assign s.out_last  = (r_state == S_UNLOAD) && w_last_beat;
  assign s.out_data  = w_out_data;
  assign s.out_flags = r_flags;
  assign s.out_iter  = r_out_iter;
  assign o_busy      = (r_state == S_START) || (r_state == S_RUN);
  assign o_core_rst  = rst | r_rst_pulse;
  assign o_core_en   = w_core_en;
  assign o_core_sig  = r_sig;
endmodule

// File: tb/tb_ldpc_frame_ctrl.sv
// Directed bench for ldpc_frame_ctrl with a behavioural ldpc_core stub.
module tb_ldpc_frame_ctrl;
  localparam int DW      = 5;
  localparam int R       = 24;
  localparam int D       = 96;
  localparam int MAX_CYC = 40;
  localparam int IT_W    = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ldpc_frame_ctrl_if #(.data_w(DW), .D(D), .it_w(IT_W)) bus ();

  logic                  busy, core_rst, core_en;
  logic [R*D*DW-1:0]     core_sig;
  logic [R*D-1:0]        core_res;
  logic [1:0]            core_status = 2'b00;
  logic [D-1:0]          exp_res [R];

  ldpc_frame_ctrl #(.data_w(DW), .R(R), .D(D), .MAX_CYC(MAX_CYC), .it_w(IT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .s             (bus),
    .o_busy        (busy),
    .o_core_rst    (core_rst),
    .o_core_en     (core_en),
    .o_core_sig    (core_sig),
    .i_core_res    (core_res),
    .i_core_status (core_status)
  );

  int vectors = 0;
  int miscompares = 0;

  // Core stub: terminates with stub_code after stub_n enabled cycles (never when stub_n == 0).
  int         stub_n = 0;
  logic [1:0] stub_code = 2'b01;
  int         stub_cnt = 0;
  always @(posedge clk) begin
    if (core_rst) begin
      stub_cnt    <= 0;
      core_status <= 2'b00;
    end else if (core_en) begin
      stub_cnt <= stub_cnt + 1;
      if (stub_n != 0 && stub_cnt + 1 == stub_n) core_status <= stub_code;
    end
  end

  always_comb begin
    core_res = '0;
    for (int b = 0; b < R; b++) core_res[b*D +: D] = exp_res[b];
  end

  int en_cycles = 0, pulses = 0, en_bad = 0, rdy_bad = 0, sig_bad = 0;
  logic [R*D*DW-1:0] prev_sig = '0;
  logic prev_ready = 1'b1, prev_rst = 1'b1;
  always @(negedge clk) begin
    if (core_en) en_cycles++;
    if (core_rst && !rst) pulses++;
    if (core_en && (core_status != 2'b00 || bus.out_valid)) en_bad++;
    if (bus.in_ready && (busy || bus.out_valid)) rdy_bad++;
    if (!rst && !prev_rst && !prev_ready && core_sig !== prev_sig) sig_bad++;
    prev_sig   = core_sig;
    prev_ready = bus.in_ready;
    prev_rst   = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [D*DW-1:0] llr_beat(input int f, input int b);
    logic [D*DW-1:0] v;
    for (int i = 0; i < D; i++) v[i*DW +: DW] = DW'((f*7 + b*3 + i) % 32);
    return v;
  endfunction

  // Index of the first frame-buffer beat that differs from frame f, or -1.
  function automatic int sig_diff_beat(input int f);
    for (int b = 0; b < R; b++)
      if (core_sig[b*D*DW +: D*DW] !== llr_beat(f, b)) return b;
    return -1;
  endfunction

  task automatic set_res(input bit zero);
    for (int b = 0; b < R; b++) exp_res[b] = zero ? '0 : {$urandom, $urandom, $urandom};
  endtask

  task automatic send_frame(input int f, input int nbeats, input bit gaps);
    int b = 0;
    int guard = 0;
    while (b < nbeats && guard < 5000) begin
      bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data  = llr_beat(f, b);
      if (bus.in_valid && bus.in_ready) b++;
      tick();
      guard++;
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (b != nbeats) begin
      miscompares++;
      $display("FAIL send_timeout: accepted %0d beats, expected %0d", b, nbeats);
    end
  endtask

  task automatic recv_frame(input bit zero_exp, input bit stall);
    int b = 0;
    int guard = 0;
    int stall_bad = 0;
    bit do_stall = stall;
    logic [D-1:0] held;
    logic [D-1:0] exp_d;
    bus.out_ready = 1'b1;
    while (b < R && guard < 2000) begin
      if (do_stall && b == 12 && bus.out_valid) begin
        bus.out_ready = 1'b0;
        held = bus.out_data;
        for (int k = 0; k < 10; k++) begin
          tick();
          if (bus.out_data !== held || bus.out_valid !== 1'b1 || bus.out_last !== 1'b0) stall_bad++;
        end
        bus.out_ready = 1'b1;
        do_stall = 1'b0;
        vectors++;
        if (stall_bad != 0) begin
          miscompares++;
          $display("FAIL stall_stable: %0d unstable cycles, expected 0", stall_bad);
        end
      end
      if (bus.out_valid) begin
        exp_d = zero_exp ? '0 : exp_res[b];
        vectors++;
        if (bus.out_data !== exp_d) begin
          miscompares++;
          $display("FAIL out_data beat %0d: got %h expected %h", b, bus.out_data, exp_d);
        end
        vectors++;
        if (bus.out_last !== (b == R - 1)) begin
          miscompares++;
          $display("FAIL out_last beat %0d: got %b expected %b", b, bus.out_last, (b == R - 1));
        end
        b++;
      end
      tick();
      guard++;
    end
    vectors++;
    if (b != R || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL recv_end: beats %0d valid %b ready %b, expected %0d 0 1",
               b, bus.out_valid, bus.in_ready, R);
    end
  endtask

  task automatic check_result(input string nm, input logic [1:0] flags, input int iter,
                              input int en_exp, input int en_got, input int p_got);
    vectors++;
    if (bus.out_flags !== flags || bus.out_iter !== IT_W'(iter)) begin
      miscompares++;
      $display("FAIL %s result: flags %b iter %0d, expected %b %0d", nm, bus.out_flags, bus.out_iter, flags, iter);
    end
    vectors++;
    if (en_got != en_exp || p_got != 1) begin
      miscompares++;
      $display("FAIL %s core_ctl: en cycles %0d pulses %0d, expected %0d 1", nm, en_got, p_got, en_exp);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    set_res(1'b1);
    tick(); tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || busy !== 1'b0 || core_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: valid %b last %b busy %b en %b, expected 0 0 0 0",
               bus.out_valid, bus.out_last, busy, core_en);
    end
    vectors++;
    if (core_rst !== 1'b1 || bus.out_flags !== 2'b00 || bus.out_iter !== '0 || core_sig !== '0) begin
      miscompares++;
      $display("FAIL reset_regs: core_rst %b flags %b iter %0d, expected 1 00 0 with empty buffer",
               core_rst, bus.out_flags, bus.out_iter);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (core_rst !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: core_rst %b in_ready %b, expected 0 1", core_rst, bus.in_ready);
    end
  endtask

  task automatic test_clean_frame();
    int e0 = en_cycles;
    int p0 = pulses;
    stub_n = 1; stub_code = 2'b01;
    set_res(1'b1);
    send_frame(1, R, 1'b0);
    vectors++;
    if (sig_diff_beat(1) != -1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL clean_sig: first bad beat %0d busy %b, expected -1 1", sig_diff_beat(1), busy);
    end
    recv_frame(1'b1, 1'b0);
    check_result("clean", 2'b01, 1, 1, en_cycles - e0, pulses - p0);
  endtask

  task automatic test_back_pressure();
    int e0 = en_cycles;
    int p0 = pulses;
    stub_n = 5; stub_code = 2'b01;
    set_res(1'b0);
    send_frame(2, R, 1'b1);
    vectors++;
    if (sig_diff_beat(2) != -1) begin
      miscompares++;
      $display("FAIL bp_sig: first bad beat %0d, expected -1", sig_diff_beat(2));
    end
    recv_frame(1'b0, 1'b1);
    check_result("backpressure", 2'b01, 5, 5, en_cycles - e0, pulses - p0);
  endtask

  task automatic test_watchdog();
    int e0 = en_cycles;
    int p0 = pulses;
    stub_n = 0;
    set_res(1'b0);
    send_frame(3, R, 1'b0);
    recv_frame(1'b1, 1'b0);
    check_result("watchdog", 2'b11, MAX_CYC, MAX_CYC, en_cycles - e0, pulses - p0);
  endtask

  task automatic test_core_limit();
    int e0 = en_cycles;
    int p0 = pulses;
    stub_n = 32; stub_code = 2'b10;
    set_res(1'b0);
    send_frame(4, R, 1'b0);
    recv_frame(1'b0, 1'b0);
    check_result("core_limit", 2'b10, 32, 32, en_cycles - e0, pulses - p0);
  endtask

  task automatic test_reset_mid_frame();
    int e0 = en_cycles;
    int p0 = pulses;
    send_frame(5, 11, 1'b0);
    rst = 1'b1;
    #1;
    vectors++;
    if (core_rst !== 1'b1 || core_sig !== '0) begin
      miscompares++;
      $display("FAIL midrst_hold: core_rst %b, expected 1 with empty buffer", core_rst);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (en_cycles != e0 || pulses != p0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_discard: en %0d pulses %0d ready %b, expected 0 0 1",
               en_cycles - e0, pulses - p0, bus.in_ready);
    end
    stub_n = 3; stub_code = 2'b01;
    set_res(1'b0);
    send_frame(6, R, 1'b0);
    vectors++;
    if (sig_diff_beat(6) != -1) begin
      miscompares++;
      $display("FAIL midrst_sig: first bad beat %0d, expected -1", sig_diff_beat(6));
    end
    recv_frame(1'b0, 1'b0);
    check_result("midrst", 2'b01, 3, 3, en_cycles - e0, pulses - p0);
  endtask

  task automatic test_back_to_back();
    int e0 = en_cycles;
    int p0 = pulses;
    int guard = 0;
    int ready_bad = 0;
    stub_n = 2; stub_code = 2'b01;
    set_res(1'b0);
    send_frame(7, R, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = llr_beat(8, 0);
    while (!bus.out_valid && guard < 200) begin
      if (bus.in_ready !== 1'b0) ready_bad++;
      tick();
      guard++;
    end
    vectors++;
    if (ready_bad != 0 || !bus.out_valid) begin
      miscompares++;
      $display("FAIL b2b_ready: %0d ready cycles, reached unload %b, expected 0 1", ready_bad, bus.out_valid);
    end
    recv_frame(1'b0, 1'b0);
    bus.in_valid = 1'b0;
    vectors++;
    if (sig_diff_beat(7) != -1) begin
      miscompares++;
      $display("FAIL b2b_sig: first bad beat %0d, expected -1", sig_diff_beat(7));
    end
    check_result("b2b", 2'b01, 2, 2, en_cycles - e0, pulses - p0);
  endtask

  task automatic test_monitors();
    tick();
    vectors++;
    if (en_bad != 0 || rdy_bad != 0 || sig_bad != 0) begin
      miscompares++;
      $display("FAIL monitors: en_bad %0d rdy_bad %0d sig_bad %0d, expected 0 0 0", en_bad, rdy_bad, sig_bad);
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_back_pressure();
    test_watchdog();
    test_core_limit();
    test_reset_mid_frame();
    test_back_to_back();
    test_monitors();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
